// File: rtl/tlul_pkg.sv
// tlul_pkg: TL-UL channel structs and opcodes shared by crossbar devices.
package tlul_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;
  localparam int TL_DBW = TL_DW / 8;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

// File: rtl/tlul_sram_adapter_pkg.sv
// tlul_sram_adapter_pkg: response-tracking entry and lane helpers for the SRAM adapter.
package tlul_sram_adapter_pkg;
  import tlul_pkg::*;

  typedef struct packed {
    logic [2:0]        rsp_op;
    logic [TL_SZW-1:0] size;
    logic [TL_AIW-1:0] source;
    logic              err;
    logic              is_read;
  } rsp_entry_t;

  localparam int RspW = $bits(rsp_entry_t);

  // Byte lanes legally touched by an access of the given size and low address bits.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr);
    return size == 2'd0 ? 4'b0001 << addr :
           size == 2'd1 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction

  function automatic logic [31:0] expand_mask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction
endpackage

// File: rtl/tlul_fifo_sync.sv
// tlul_fifo_sync: small synchronous FIFO with full/empty/occupancy status.
module tlul_fifo_sync #(
  parameter int Width = 8,
  parameter int Depth = 2,
  localparam int CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wvalid_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  depth_o
);
  localparam int PtrW = Depth > 1 ? $clog2(Depth) : 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr, r_rptr;
  logic [CntW-1:0]  r_cnt;
  logic             w_push, w_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return p == PtrW'(Depth - 1) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = r_cnt == CntW'(Depth);
  assign empty_o = r_cnt == '0;
  assign depth_o = r_cnt;
  assign rdata_o = r_mem[r_rptr];
  assign w_push  = wvalid_i & ~full_o;
  assign w_pop   = rready_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      r_wptr <= w_push ? ptr_inc(r_wptr) : r_wptr;
      r_rptr <= w_pop ? ptr_inc(r_rptr) : r_rptr;
      r_cnt  <= r_cnt + CntW'(w_push) - CntW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= wdata_i;
  end
endmodule

// File: rtl/tlul_sram_adapter.sv
// tlul_sram_adapter: TL-UL device port terminating into a single-port SRAM
// req/gnt/rvalid interface, with protocol error checks and in-order responses.
module tlul_sram_adapter
  import tlul_pkg::*;
  import tlul_sram_adapter_pkg::*;
#(
  parameter int SramAw      = 12,
  parameter int SramDw      = 32,
  parameter int Outstanding = 2,
  parameter bit ErrOnWrite  = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  tl_h2d_t           tl_i,
  output tl_d2h_t           tl_o,
  output logic              req_o,
  input  logic              gnt_i,
  output logic              we_o,
  output logic [SramAw-1:0] addr_o,
  output logic [SramDw-1:0] wdata_o,
  output logic [SramDw-1:0] wmask_o,
  input  logic              rvalid_i,
  input  logic [SramDw-1:0] rdata_i
);
  localparam int CntW = 3;
  localparam int DepW = $clog2(Outstanding + 1);

  logic [CntW-1:0]   r_cnt, r_rd_out;
  logic              w_is_get, w_is_put, w_misalign, w_err;
  logic [3:0]        w_lanes;
  logic              w_space, w_req, w_accept, w_retire, w_rd_push, w_rd_pop;
  rsp_entry_t        w_push_ent, w_head;
  logic [RspW-1:0]   w_head_raw;
  logic              w_req_full, w_req_empty, w_rd_full, w_rd_empty;
  logic [DepW-1:0]   w_req_depth, w_rd_depth;
  logic [SramDw-1:0] w_rd_data;
  logic              w_unused;

  always_comb begin
    w_is_get   = tl_i.a_opcode == Get;
    w_is_put   = tl_i.a_opcode == PutFullData || tl_i.a_opcode == PutPartialData;
    w_lanes    = lane_mask(tl_i.a_size, tl_i.a_address[1:0]);
    w_misalign = tl_i.a_size == 2'd1 ? tl_i.a_address[0] :
                 tl_i.a_size == 2'd2 ? |tl_i.a_address[1:0] : 1'b0;
    w_err      = !(w_is_get || w_is_put) || tl_i.a_size == 2'd3 || w_misalign ||
                 |(tl_i.a_mask & ~w_lanes) ||
                 (tl_i.a_opcode == PutFullData && tl_i.a_mask != w_lanes) ||
                 (w_is_put && ErrOnWrite);
  end

  // No bypass: a retire in the same cycle does not free a slot.
  assign w_space  = r_cnt < CntW'(Outstanding);
  assign w_req    = tl_i.a_valid & ~w_err & w_space;
  assign w_accept = tl_i.a_valid & w_space & (w_err | gnt_i);

  assign req_o   = w_req;
  assign we_o    = w_req & w_is_put;
  assign addr_o  = tl_i.a_address[SramAw+1:2];
  assign wdata_o = SramDw'(tl_i.a_data);
  assign wmask_o = SramDw'(expand_mask(tl_i.a_mask));

  always_comb begin
    w_push_ent         = '0;
    w_push_ent.rsp_op  = w_is_get ? 3'(AccessAckData) : 3'(AccessAck);
    w_push_ent.size    = tl_i.a_size;
    w_push_ent.source  = tl_i.a_source;
    w_push_ent.err     = w_err;
    w_push_ent.is_read = w_is_get;
  end

  tlul_fifo_sync #(.Width(RspW), .Depth(Outstanding)) u_reqfifo (
    .clk_i, .rst_ni,
    .wvalid_i (w_accept),
    .wdata_i  (w_push_ent),
    .rready_i (w_retire),
    .rdata_o  (w_head_raw),
    .full_o   (w_req_full),
    .empty_o  (w_req_empty),
    .depth_o  (w_req_depth)
  );

  // Read data is only captured while a granted good read is still awaiting it.
  assign w_rd_push = rvalid_i & (r_rd_out != '0);

  tlul_fifo_sync #(.Width(SramDw), .Depth(Outstanding)) u_rdfifo (
    .clk_i, .rst_ni,
    .wvalid_i (w_rd_push),
    .wdata_i  (rdata_i),
    .rready_i (w_rd_pop),
    .rdata_o  (w_rd_data),
    .full_o   (w_rd_full),
    .empty_o  (w_rd_empty),
    .depth_o  (w_rd_depth)
  );

  assign w_head   = rsp_entry_t'(w_head_raw);
  assign w_retire = tl_o.d_valid & tl_i.d_ready;
  assign w_rd_pop = w_retire & w_head.is_read & ~w_head.err;

  always_comb begin
    tl_o          = '0;
    tl_o.a_ready  = w_accept;
    tl_o.d_valid  = ~w_req_empty & (~w_head.is_read | w_head.err | ~w_rd_empty);
    tl_o.d_opcode = w_head.rsp_op;
    tl_o.d_size   = w_head.size;
    tl_o.d_source = w_head.source;
    tl_o.d_error  = w_head.err;
    tl_o.d_data   = w_head.is_read ? (w_head.err ? '1 : TL_DW'(w_rd_data)) : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt    <= '0;
      r_rd_out <= '0;
    end else begin
      r_cnt    <= r_cnt + CntW'(w_accept) - CntW'(w_retire);
      r_rd_out <= r_rd_out + CntW'(w_req & gnt_i & ~w_is_put) - CntW'(w_rd_push);
    end
  end

  assign w_unused = ^{tl_i.a_address[TL_AW-1:SramAw+2], tl_i.a_param, w_req_full,
                      w_req_depth, w_rd_depth};

  ap_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rvalid_i |-> r_rd_out != '0);
  ap_rdfifo_room: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rvalid_i |-> !w_rd_full);
endmodule

// File: tb/tb_tlul_sram_adapter.sv
// tb_tlul_sram_adapter: table-driven and sequence checks of the TL-UL SRAM adapter
// against an SRAM model, a reference memory and an in-order response scoreboard.
module tb_tlul_sram_adapter;
  import tlul_pkg::*;

  localparam int Aw = 12;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  tl_h2d_t       h2d;
  tl_d2h_t       d2h;
  logic          req_o, gnt_i, we_o, rvalid_i;
  logic [Aw-1:0] addr_o;
  logic [31:0]   wdata_o, wmask_o, rdata_i;

  always #5 clk = ~clk;

  tlul_sram_adapter #(.SramAw(Aw), .SramDw(32), .Outstanding(2), .ErrOnWrite(1'b0)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .tl_i     (h2d),
    .tl_o     (d2h),
    .req_o    (req_o),
    .gnt_i    (gnt_i),
    .we_o     (we_o),
    .addr_o   (addr_o),
    .wdata_o  (wdata_o),
    .wmask_o  (wmask_o),
    .rvalid_i (rvalid_i),
    .rdata_i  (rdata_i)
  );

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [7:0]  src;
    logic        err;
  } vec_t;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  src;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[15];
  int          n_tests = 0, n_fail = 0, wr_cnt = 0;
  logic [31:0] mem[4096], ref_mem[4096];

  function automatic logic [31:0] bytes_to_bits(input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = {8{m[b]}};
    return r;
  endfunction

  function automatic vec_t mk(input logic [2:0] op, input logic [1:0] size, input logic [31:0] addr,
                              input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src,
                              input logic err);
    vec_t v;
    v.op = op; v.size = size; v.addr = addr; v.mask = mask; v.data = data; v.src = src; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM model: writes land on the grant edge, read data returns one cycle after grant.
  initial begin
    logic hs, hw;
    logic [Aw-1:0] ha;
    logic [31:0] hd, hm;
    rvalid_i = 1'b0;
    rdata_i  = '0;
    forever begin
      @(negedge clk);
      hs = req_o && gnt_i && rst_ni;
      hw = we_o; ha = addr_o; hd = wdata_o; hm = wmask_o;
      @(posedge clk); #1;
      rvalid_i = 1'b0;
      if (hs && rst_ni) begin
        if (hw) begin
          mem[ha] = (mem[ha] & ~hm) | (hd & hm);
          wr_cnt++;
        end else begin
          rvalid_i = 1'b1;
          rdata_i  = mem[ha];
        end
      end
    end
  end

  // D-channel monitor: every handshake is compared to the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_ni && d2h.d_valid && h2d.d_ready) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_d: got source %h with nothing expected", d2h.d_source);
        end else begin
          e = sb.pop_front();
          chk("d_opcode", 32'(d2h.d_opcode), 32'(e.op));
          chk("d_error",  32'(d2h.d_error),  32'(e.err));
          chk("d_data",   d2h.d_data,        e.data);
          chk("d_source", 32'(d2h.d_source), 32'(e.src));
          chk("d_size",   32'(d2h.d_size),   32'(e.size));
          chk("d_param",  32'(d2h.d_param),  32'd0);
        end
      end
    end
  end

  task automatic set_a(input vec_t v);
    h2d.a_valid   = 1'b1;
    h2d.a_opcode  = v.op;
    h2d.a_size    = v.size;
    h2d.a_address = v.addr;
    h2d.a_mask    = v.mask;
    h2d.a_data    = v.data;
    h2d.a_source  = v.src;
  endtask

  task automatic wait_accept(input vec_t v);
    int k;
    exp_t e;
    logic [11:0] w;
    logic [31:0] m;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d2h.a_ready) break;
      @(posedge clk); #1;
    end
    if (k == 20) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: source %h not accepted within 20 cycles", v.src);
    end else begin
      w = v.addr[13:2];
      m = bytes_to_bits(v.mask);
      chk("req_o", 32'(req_o), 32'(!v.err));
      if (!v.err) begin
        chk("we_o", 32'(we_o), 32'(v.op != 3'd4));
        chk("addr_o", 32'(addr_o), 32'(w));
        if (v.op != 3'd4) begin
          chk("wmask_o", wmask_o, m);
          chk("wdata_o", wdata_o, v.data);
        end
      end
      e.op   = v.op == 3'd4 ? 3'd1 : 3'd0;
      e.size = v.size;
      e.src  = v.src;
      e.err  = v.err;
      e.data = v.op != 3'd4 ? 32'h0 : v.err ? 32'hFFFF_FFFF : ref_mem[w];
      sb.push_back(e);
      if (!v.err && v.op != 3'd4) ref_mem[w] = (ref_mem[w] & ~m) | (v.data & m);
      @(posedge clk); #1;
    end
    h2d.a_valid = 1'b0;
  endtask

  task automatic send(input vec_t v);
    set_a(v);
    wait_accept(v);
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 60 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 32'h5A5A_0000 | 32'(i);
      ref_mem[i] = 32'h5A5A_0000 | 32'(i);
    end
    h2d = '0;
    h2d.d_ready = 1'b1;
    gnt_i = 1'b1;

    tbl[0]  = mk(3'd0, 2'd2, 32'h10, 4'hF, 32'hDEAD_BEEF,  8'd5,  1'b0);
    tbl[1]  = mk(3'd4, 2'd2, 32'h10, 4'hF, 32'h0,          8'd1,  1'b0);
    tbl[2]  = mk(3'd1, 2'd1, 32'h22, 4'hC, 32'hABCD_0000,  8'd2,  1'b0);
    tbl[3]  = mk(3'd4, 2'd2, 32'h20, 4'hF, 32'h0,          8'd3,  1'b0);
    tbl[4]  = mk(3'd4, 2'd2, 32'h03, 4'hF, 32'h0,          8'd4,  1'b1);
    tbl[5]  = mk(3'd4, 2'd3, 32'h00, 4'hF, 32'h0,          8'd6,  1'b1);
    tbl[6]  = mk(3'd2, 2'd2, 32'h00, 4'hF, 32'h0,          8'd7,  1'b1);
    tbl[7]  = mk(3'd4, 2'd0, 32'h01, 4'h2, 32'h0,          8'd8,  1'b0);
    tbl[8]  = mk(3'd4, 2'd0, 32'h01, 4'h4, 32'h0,          8'd9,  1'b1);
    tbl[9]  = mk(3'd0, 2'd1, 32'h02, 4'h4, 32'h1234_5678,  8'd10, 1'b1);
    tbl[10] = mk(3'd1, 2'd1, 32'h02, 4'h8, 32'hAA00_0000,  8'd11, 1'b0);
    tbl[11] = mk(3'd4, 2'd2, 32'h00, 4'hF, 32'h0,          8'd12, 1'b0);
    tbl[12] = mk(3'd0, 2'd1, 32'h02, 4'hC, 32'hBEEF_0000,  8'd13, 1'b0);
    tbl[13] = mk(3'd1, 2'd1, 32'h01, 4'h3, 32'h0,          8'd14, 1'b1);
    tbl[14] = mk(3'd4, 2'd2, 32'h00, 4'hF, 32'h0,          8'd15, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_d_valid", 32'(d2h.d_valid), 32'd0);
    chk("rst_a_ready", 32'(d2h.a_ready), 32'd0);
    chk("rst_req_o",   32'(req_o),       32'd0);
    chk("rst_we_o",    32'(we_o),        32'd0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) send(tbl[i]);
    drain();

    // Three Gets with D stalled: the third waits for the first retire.
    h2d.d_ready = 1'b0;
    send(mk(3'd4, 2'd2, 32'h10, 4'hF, 32'h0, 8'd1, 1'b0));
    send(mk(3'd4, 2'd2, 32'h20, 4'hF, 32'h0, 8'd2, 1'b0));
    set_a(mk(3'd4, 2'd2, 32'h30, 4'hF, 32'h0, 8'd3, 1'b0));
    repeat (3) begin
      @(negedge clk);
      chk("full_a_ready", 32'(d2h.a_ready), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("stall_d_valid", 32'(d2h.d_valid), 32'd1);
    chk("stall_d_source", 32'(d2h.d_source), 32'd1);
    @(posedge clk); #1;
    h2d.d_ready = 1'b1;
    wait_accept(mk(3'd4, 2'd2, 32'h30, 4'hF, 32'h0, 8'd3, 1'b0));
    drain();

    // Grant withheld for five cycles: request stays up, exactly one write lands.
    w0 = wr_cnt;
    gnt_i = 1'b0;
    set_a(mk(3'd1, 2'd1, 32'h40, 4'h3, 32'h0000_1234, 8'd20, 1'b0));
    repeat (5) begin
      @(negedge clk);
      chk("nognt_a_ready", 32'(d2h.a_ready), 32'd0);
      chk("nognt_req_o",   32'(req_o),       32'd1);
      @(posedge clk); #1;
    end
    gnt_i = 1'b1;
    wait_accept(mk(3'd1, 2'd1, 32'h40, 4'h3, 32'h0000_1234, 8'd20, 1'b0));
    drain();
    chk("sram_writes", 32'(wr_cnt - w0), 32'd1);
    send(mk(3'd4, 2'd2, 32'h40, 4'hF, 32'h0, 8'd21, 1'b0));
    drain();

    // Reset with two reads outstanding, then a fresh Get.
    h2d.d_ready = 1'b0;
    send(mk(3'd4, 2'd2, 32'h10, 4'hF, 32'h0, 8'd22, 1'b0));
    send(mk(3'd4, 2'd2, 32'h20, 4'hF, 32'h0, 8'd23, 1'b0));
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    chk("prerst_d_valid", 32'(d2h.d_valid), 32'd1);
    @(posedge clk); #1;
    rst_ni = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_d_valid", 32'(d2h.d_valid), 32'd0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    h2d.d_ready = 1'b1;
    @(negedge clk);
    chk("postrst_d_valid", 32'(d2h.d_valid), 32'd0);
    @(posedge clk); #1;
    send(mk(3'd4, 2'd2, 32'h10, 4'hF, 32'h0, 8'd30, 1'b0));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1);
  end
endmodule
